// File: rtl/switch_port_arbiter.sv
// ============================================================================
// Module   : switch_port_arbiter
// Brief    : Round-robin arbiter for one output port of the 16x16 switch;
//            drives the Gray-coded I/O cell select, output enable and grants.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_port_arbiter #(
  parameter int MAX_HOLD = 64,
  parameter int HOLD_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] req,
  output logic [15:0] gnt,
  output logic [3:0]  sel,
  output logic        oe,
  output logic [3:0]  grant_idx,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACTIVE = 2'd2,
    S_TURN   = 2'd3
  } state_t;

  localparam bit                c_hold_en   = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] c_hold_last = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  state_t            state_q, state_d;
  logic [3:0]        ptr_q, ptr_d;
  logic [3:0]        win_q, win_d;
  logic [3:0]        sel_q, sel_d;
  logic [15:0]       gnt_q, gnt_d;
  logic              oe_q, oe_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;

  logic [3:0]        rr_idx;
  logic [3:0]        rr_cand;
  logic              rr_found;
  logic              hold_done;

  // Search starts at the pointer and wraps; first requester found wins.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    rr_cand  = ptr_q;
    for (int k = 0; k < 16; k++) begin
      rr_cand = ptr_q + 4'(k);
      if (!rr_found && req[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  assign hold_done = c_hold_en && (cnt_q == c_hold_last);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    oe_d    = oe_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        oe_d  = 1'b0;
        if (en && rr_found) begin
          win_d   = rr_idx;
          sel_d   = rr_idx ^ (rr_idx >> 1);
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        // Winner must still be asking after the mux settled, else abandon.
        if (en && req[win_q]) begin
          state_d = S_ACTIVE;
          gnt_d   = 16'b1 << win_q;
          oe_d    = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACTIVE: begin
        if (!req[win_q] || !en || hold_done) begin
          state_d = S_TURN;
          gnt_d   = '0;
          oe_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + HOLD_W'(1);
        end
      end
      S_TURN: begin
        cnt_d   = '0;
        ptr_d   = win_q + 4'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      oe_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      oe_q    <= oe_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign oe        = oe_q;
  assign grant_idx = win_q;
  assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_switch_port_arbiter.sv
// ============================================================================
// Module   : tb_switch_port_arbiter
// Brief    : Self-checking bench for switch_port_arbiter with a grant scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_switch_port_arbiter;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] req;
  logic [15:0] gnt;
  logic [3:0]  sel;
  logic        oe;
  logic [3:0]  grant_idx;
  logic        busy;

  switch_port_arbiter #(.MAX_HOLD(4), .HOLD_W(16)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .oe        (oe),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int dur;
    int gap;
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  int         n_chk    = 0;
  int         n_pass   = 0;
  int         n_grants = 0;
  int         act_len  = 0;
  int         low_len  = 0;
  bit         in_grant = 1'b0;
  logic [3:0] gray_tbl [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input int dur, input int gap);
    exp_t e;
    e.idx = idx;
    e.dur = dur;
    e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic wait_gnt(output int cyc);
    cyc = 0;
    while (gnt == 16'h0 && cyc < 20) begin
      step();
      cyc++;
    end
    if (gnt == 16'h0) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (busy && cyc < 20) begin
      step();
      cyc++;
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic grant_once(input logic [15:0] r, input int idx);
    int c;
    push(idx, 1, 0);
    req = r;
    wait_gnt(c);
    check("latency", c, 32'd2);
    req = 16'h0;
    wait_idle();
  endtask

  // Grant monitor: pops an expectation at every new grant and times it.
  always @(negedge clk) begin
    check("oe_eq_gnt_nz", {31'd0, oe}, {31'd0, (gnt != 16'h0)});
    check("onehot", {31'd0, ($countones(gnt) <= 1)}, 32'd1);
    if (gnt != 16'h0 && !in_grant) begin
      in_grant = 1'b1;
      act_len  = 1;
      n_grants++;
      if (sb.size() == 0) begin
        check("unexpected_grant", {16'h0, gnt}, 32'd0);
        cur.idx = 0;
        cur.dur = 0;
        cur.gap = 0;
      end else begin
        cur = sb.pop_front();
        check("sb_gnt", {16'h0, gnt}, 32'd1 << cur.idx);
        check("sb_sel", {28'h0, sel}, {28'h0, gray_tbl[cur.idx]});
        check("sb_idx", {28'h0, grant_idx}, cur.idx);
        if (cur.gap != 0) check("sb_gap", low_len, cur.gap);
      end
    end else if (gnt != 16'h0) begin
      act_len++;
    end else if (in_grant) begin
      in_grant = 1'b0;
      if (cur.dur != 0) check("sb_hold", act_len, cur.dur);
      low_len = 1;
    end else begin
      low_len++;
    end
  end

  initial begin
    int c;
    int base;
    rst = 1'b1;
    en  = 1'b0;
    req = 16'h0;
    repeat (2) step();
    check("rst_gnt", {16'h0, gnt}, 32'd0);
    check("rst_sel", {28'h0, sel}, 32'd0);
    check("rst_oe", {31'd0, oe}, 32'd0);
    check("rst_idx", {28'h0, grant_idx}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    step();

    // Single request, then drop it
    en  = 1'b1;
    req = 16'h0004;
    push(2, 3, 0);
    step();
    check("t1_setup_busy", {31'd0, busy}, 32'd1);
    check("t1_setup_oe", {31'd0, oe}, 32'd0);
    step();
    check("t1_gnt", {16'h0, gnt}, 32'h0004);
    check("t1_sel", {28'h0, sel}, 32'h3);
    check("t1_oe", {31'd0, oe}, 32'd1);
    check("t1_idx", {28'h0, grant_idx}, 32'd2);
    step();
    step();
    req = 16'h0;
    step();
    check("t1_turn_gnt", {16'h0, gnt}, 32'd0);
    check("t1_turn_oe", {31'd0, oe}, 32'd0);
    check("t1_turn_busy", {31'd0, busy}, 32'd1);
    step();
    check("t1_idle_busy", {31'd0, busy}, 32'd0);
    check("t1_idle_sel", {28'h0, sel}, 32'h3);
    grant_once(16'h000D, 3);

    // All requesting with hold limit 4: full rotation
    do_reset();
    for (int i = 0; i < 16; i++) push(i, 4, (i == 0) ? 0 : 3);
    push(0, 0, 3);
    base = n_grants;
    req  = 16'hFFFF;
    c    = 0;
    while (n_grants < base + 17 && c < 200) begin
      step();
      c++;
    end
    check("t2_grants", n_grants - base, 32'd17);
    req = 16'h0;
    wait_idle();

    // Wrap of the round-robin pointer
    do_reset();
    grant_once(16'h0010, 4);
    grant_once(16'h0011, 0);
    grant_once(16'h0011, 4);

    // Enable dropped mid-grant
    push(8, 2, 0);
    req = 16'h0100;
    wait_gnt(c);
    step();
    en = 1'b0;
    step();
    check("t4_en_gnt", {16'h0, gnt}, 32'd0);
    check("t4_en_oe", {31'd0, oe}, 32'd0);
    req = 16'hFFFF;
    for (int i = 0; i < 8; i++) begin
      step();
      check("t4_no_grant", {16'h0, gnt}, 32'd0);
    end
    check("t4_busy", {31'd0, busy}, 32'd0);
    push(9, 0, 0);
    en = 1'b1;
    wait_gnt(c);
    check("t4_latency", c, 32'd2);
    req = 16'h0;
    wait_idle();

    // Request withdrawn during SETUP
    req = 16'h0800;
    step();
    check("t5_setup_busy", {31'd0, busy}, 32'd1);
    check("t5_setup_idx", {28'h0, grant_idx}, 32'd11);
    check("t5_setup_sel", {28'h0, sel}, 32'hE);
    req = 16'h0;
    step();
    check("t5_abort_gnt", {16'h0, gnt}, 32'd0);
    check("t5_abort_busy", {31'd0, busy}, 32'd0);
    step();
    check("t5_abort_gnt2", {16'h0, gnt}, 32'd0);
    grant_once(16'h0801, 11);

    // Reset in the middle of a grant
    push(15, 0, 0);
    req = 16'h8000;
    wait_gnt(c);
    step();
    rst = 1'b1;
    step();
    check("t6_rst_gnt", {16'h0, gnt}, 32'd0);
    check("t6_rst_oe", {31'd0, oe}, 32'd0);
    check("t6_rst_sel", {28'h0, sel}, 32'd0);
    check("t6_rst_idx", {28'h0, grant_idx}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    push(15, 0, 0);
    rst = 1'b0;
    wait_gnt(c);
    check("t6_latency", c, 32'd2);
    check("t6_sel", {28'h0, sel}, 32'h8);
    req = 16'h0;
    wait_idle();

    repeat (3) step();
    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
